// File: rtl/imem_loader_pkg.sv
// Shared encodings for the imem loader: instruction format selector,
// RV32I opcodes used by the encoder, and the canonical NOP word.
package imem_loader_pkg;

    typedef enum logic {
        ENC_R_ADD,
        ENC_I_ADDI
    } t_enc_fmt;

    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [2:0]  FUNCT3_ADD = 3'b000;
    localparam logic [31:0] NOP_INSTR  = 32'h00000013;

endpackage

// File: rtl/imem_loader_instr_encoder.sv
// Combinational fields-to-word encoder for RV32I ADD and ADDI; the inverse
// of the core decoder for these two formats.
module instr_encoder
    import imem_loader_pkg::*;
(
    input  t_enc_fmt    fmt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [11:0] imm,
    output logic [31:0] word
);

    always_comb begin
        word = '0;
        if (fmt == ENC_I_ADDI) begin
            word = {imm, rs1, FUNCT3_ADD, rd, OPC_OP_IMM};
        end else begin
            word = {7'b0000000, rs2, rs1, FUNCT3_ADD, rd, OPC_OP};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams encoded ADD/ADDI words into consecutive imem addresses from 0.
// Optional macro IMEM_LOADER_PAD_NOP_EN fills the tail of imem with NOPs.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter  int unsigned DEPTH  = 256,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  t_enc_fmt          in_fmt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [11:0]       in_imm,
    input  logic              in_last,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wr_data,
    output logic [3:0]        imem_byt_en,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic [ADDR_W:0]   word_count
);

`ifdef IMEM_LOADER_PAD_NOP_EN
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PAD, S_DONE} t_state;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} t_state;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    t_state            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       enc_word;
    logic              accept;
    logic              at_end;
    logic              restart;

    assign in_ready    = (state == S_LOAD);
    assign busy        = (state != S_IDLE) && (state != S_DONE);
    assign accept      = in_valid && in_ready;
    assign at_end      = (addr == LAST_ADDR);
    assign restart     = start && ((state == S_IDLE) || (state == S_DONE));
    assign imem_byt_en = {4{imem_wr_en}};

    instr_encoder u_encoder (
        .fmt  (in_fmt),
        .rd   (in_rd),
        .rs1  (in_rs1),
        .rs2  (in_rs2),
        .imm  (in_imm),
        .word (enc_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_LOAD;
            S_LOAD: begin
                // The last address wins over in_last: a full memory never pads.
                if (accept && at_end) begin
                    state_nxt = S_DONE;
                end else if (accept && in_last) begin
`ifdef IMEM_LOADER_PAD_NOP_EN
                    state_nxt = S_PAD;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_PAD_NOP_EN
            S_PAD: if (at_end) state_nxt = S_DONE;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr         <= '0;
            word_count   <= '0;
            imem_wr_en   <= 1'b0;
            imem_addr    <= '0;
            imem_wr_data <= '0;
            done         <= 1'b0;
            full         <= 1'b0;
        end else begin
            imem_wr_en <= 1'b0;
            if (restart) begin
                addr       <= '0;
                word_count <= '0;
                done       <= 1'b0;
                full       <= 1'b0;
            end
            if (accept) begin
                imem_wr_en   <= 1'b1;
                imem_addr    <= addr;
                imem_wr_data <= enc_word;
                addr         <= addr + ADDR_ONE;
                word_count   <= word_count + CNT_ONE;
                if (at_end) begin
                    done <= 1'b1;
                    full <= !in_last;
                end
`ifndef IMEM_LOADER_PAD_NOP_EN
                else if (in_last) begin
                    done <= 1'b1;
                end
`endif
            end
`ifdef IMEM_LOADER_PAD_NOP_EN
            if (state == S_PAD) begin
                imem_wr_en   <= 1'b1;
                imem_addr    <= addr;
                imem_wr_data <= NOP_INSTR;
                addr         <= addr + ADDR_ONE;
                word_count   <= word_count + CNT_ONE;
                if (at_end) done <= 1'b1;
            end
`endif
        end
    end

endmodule
